// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the i2c command arbiter.
package i2c_arb_pkg;

    localparam int CHIP_W = 7;
    localparam int REG_W  = 8;

    localparam logic [3:0] ST_NO_START = 4'hE;
    localparam logic [3:0] ST_TIMEOUT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RESP       = 3'd4
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin grant: the first requester found scanning upward
// from i_start (wrapping) wins.
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Outer loop walks rotation distance, inner loop finds the requester at
    // that distance; this keeps every select index a plain loop variable.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int d = 0; d < NUM_REQ; d++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_any && i_req[j] &&
                    (((j - int'(i_start) + NUM_REQ) % NUM_REQ) == d)) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin scheduler sharing one i2c master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add a busy watchdog in WAIT_DONE.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int START_WAIT     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ-1:0]        req_write_mode,
    input  logic [NUM_REQ*CHIP_W-1:0] req_chip_addr,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [3:0]                rsp_status,
    output logic [CHIP_W-1:0]         m_chip_addr,
    output logic [REG_W-1:0]          m_reg_addr,
    output logic [DATA_W-1:0]         m_data_in,
    output logic                      m_write_mode,
    output logic                      m_write_en,
    output logic                      m_read_en,
    input  logic [DATA_W-1:0]         m_data_out,
    input  logic [3:0]                m_status,
    input  logic                      m_busy,
    output logic                      arb_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SW_W  = $clog2(START_WAIT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || START_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("i2c_cmd_arbiter: parameter out of range");
    end

    arb_state_e          r_state, w_next;
    logic [IDX_W-1:0]    r_rr_ptr, r_rr_next, w_gnt_idx, w_next_ptr;
    logic [NUM_REQ-1:0]  r_gnt_oh, w_gnt_oh;
    logic                w_gnt_any, w_grant_ok, w_start_to, w_timeout;
    logic                r_rnw;
    logic [SW_W-1:0]     r_start_cnt;
    logic                w_cmd_rnw, w_cmd_wm;
    logic [CHIP_W-1:0]   w_cmd_chip;
    logic [REG_W-1:0]    w_cmd_reg;
    logic [DATA_W-1:0]   w_cmd_data;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (req_valid),
        .i_start (r_rr_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    always_comb begin
        w_cmd_rnw  = 1'b0;
        w_cmd_wm   = 1'b0;
        w_cmd_chip = '0;
        w_cmd_reg  = '0;
        w_cmd_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt_oh[j]) begin
                w_cmd_rnw  = req_rnw[j];
                w_cmd_wm   = req_write_mode[j];
                w_cmd_chip = req_chip_addr[j*CHIP_W +: CHIP_W];
                w_cmd_reg  = req_reg_addr[j*REG_W +: REG_W];
                w_cmd_data = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    // A busy master (including one left hanging by a watchdog abort) blocks grants.
    assign w_grant_ok = w_gnt_any && !m_busy;
    assign w_start_to = !m_busy && (r_start_cnt == SW_W'(START_WAIT - 1));
    assign arb_busy   = (r_state != S_IDLE);

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    assign w_timeout = m_busy && (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     r_wd_cnt <= '0;
        else if (r_state == S_WAIT_DONE) r_wd_cnt <= r_wd_cnt + 32'd1;
        else                            r_wd_cnt <= '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_grant_ok) w_next = S_ISSUE;
            S_ISSUE:      w_next = S_WAIT_START;
            S_WAIT_START: begin
                if (m_busy)          w_next = S_WAIT_DONE;
                else if (w_start_to) w_next = S_RESP;
            end
            S_WAIT_DONE:  if (!m_busy || w_timeout) w_next = S_RESP;
            S_RESP:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_rr_next    <= '0;
            r_gnt_oh     <= '0;
            r_rnw        <= 1'b0;
            r_start_cnt  <= '0;
            req_ack      <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_status   <= '0;
            m_chip_addr  <= '0;
            m_reg_addr   <= '0;
            m_data_in    <= '0;
            m_write_mode <= 1'b0;
            m_write_en   <= 1'b0;
            m_read_en    <= 1'b0;
        end else begin
            req_ack    <= '0;
            rsp_valid  <= '0;
            m_write_en <= 1'b0;
            m_read_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        req_ack      <= w_gnt_oh;
                        r_gnt_oh     <= w_gnt_oh;
                        r_rr_next    <= w_next_ptr;
                        r_rnw        <= w_cmd_rnw;
                        m_chip_addr  <= w_cmd_chip;
                        m_reg_addr   <= w_cmd_reg;
                        m_data_in    <= w_cmd_data;
                        m_write_mode <= w_cmd_wm;
                    end
                end
                S_ISSUE: begin
                    m_write_en  <= ~r_rnw;
                    m_read_en   <= r_rnw;
                    r_start_cnt <= '0;
                end
                S_WAIT_START: begin
                    if (!m_busy) r_start_cnt <= r_start_cnt + SW_W'(1);
                    if (w_start_to) begin
                        rsp_valid  <= r_gnt_oh;
                        rsp_status <= ST_NO_START;
                        rsp_data   <= '0;
                    end
                end
                S_WAIT_DONE: begin
                    if (!m_busy) begin
                        rsp_valid  <= r_gnt_oh;
                        rsp_status <= m_status;
                        rsp_data   <= r_rnw ? m_data_out : '0;
                    end else if (w_timeout) begin
                        rsp_valid  <= r_gnt_oh;
                        rsp_status <= ST_TIMEOUT;
                        rsp_data   <= '0;
                    end
                end
                S_RESP:  r_rr_ptr <= r_rr_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench for i2c_cmd_arbiter with a behavioural master/slave and a
// transaction-level reference model (rotation order, slave memory, status codes).
module tb_i2c_cmd_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int TO = 50;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid, req_rnw, req_write_mode;
    logic [N*7-1:0]  req_chip_addr;
    logic [N*8-1:0]  req_reg_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack, rsp_valid;
    logic [DW-1:0]   rsp_data, m_data_in, m_data_out;
    logic [3:0]      rsp_status, m_status;
    logic [6:0]      m_chip_addr;
    logic [7:0]      m_reg_addr;
    logic            m_write_mode, m_write_en, m_read_en, m_busy, arb_busy;

    i2c_cmd_arbiter #(.NUM_REQ(N), .DATA_W(DW), .START_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_write_mode(req_write_mode),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
        .m_write_mode(m_write_mode), .m_write_en(m_write_en), .m_read_en(m_read_en),
        .m_data_out(m_data_out), .m_status(m_status), .m_busy(m_busy), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural i2c master + slave at chip 0x0F ----------------
    bit          mm_dead = 0, mm_stuck = 0, force_busy = 0;
    int          mm_len_fix = 0;
    logic        mm_busy;
    int          mm_phase, mm_cnt;
    logic        mm_rnw;
    logic [6:0]  mm_chip;
    logic [7:0]  mm_reg;
    logic [31:0] mm_din;
    logic [31:0] slave_mem [256];

    assign m_busy = mm_busy | force_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mm_busy    <= 1'b0;
            mm_phase   <= 0;
            mm_cnt     <= 0;
            mm_rnw     <= 1'b0;
            mm_chip    <= '0;
            mm_reg     <= '0;
            mm_din     <= '0;
            m_status   <= '0;
            m_data_out <= '0;
            for (int i = 0; i < 256; i++) slave_mem[i] <= '0;
        end else begin
            case (mm_phase)
                0: if ((m_write_en || m_read_en) && !mm_dead) begin
                    mm_rnw   <= m_read_en;
                    mm_chip  <= m_chip_addr;
                    mm_reg   <= m_reg_addr;
                    mm_din   <= m_data_in;
                    mm_cnt   <= int'($urandom_range(0, 2));
                    mm_phase <= 1;
                end
                1: if (mm_cnt == 0) begin
                    mm_busy  <= 1'b1;
                    mm_cnt   <= (mm_len_fix > 0) ? mm_len_fix : int'($urandom_range(1, 6));
                    mm_phase <= 2;
                end else mm_cnt <= mm_cnt - 1;
                default: if (!mm_stuck) begin
                    if (mm_cnt == 0) begin
                        mm_busy  <= 1'b0;
                        mm_phase <= 0;
                        if (mm_chip == 7'h0F) begin
                            m_status <= 4'h8;
                            if (mm_rnw) m_data_out <= slave_mem[mm_reg];
                            else        slave_mem[mm_reg] <= mm_din;
                        end else begin
                            m_status <= 4'h1;
                            if (mm_rnw) m_data_out <= '0;
                        end
                    end else mm_cnt <= mm_cnt - 1;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    bit          pend [N];
    bit          c_rnw [N], c_wm [N];
    logic [6:0]  c_chip [N];
    logic [7:0]  c_reg [N];
    logic [31:0] c_data [N];
    int          reissue [N];
    int          rr = 0;
    logic [31:0] ref_mem [256];

    function automatic int pick();
        for (int d = 0; d < N; d++) if (pend[(rr + d) % N]) return (rr + d) % N;
        return -1;
    endfunction

    task automatic set_cmd(input int i, input bit rnw, input logic [6:0] chip,
                           input logic [7:0] rg, input logic [31:0] dat);
        c_rnw[i] = rnw; c_wm[i] = 1'($urandom_range(0, 1));
        c_chip[i] = chip; c_reg[i] = rg; c_data[i] = dat;
    endtask

    task automatic rand_cmd(input int i);
        set_cmd(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) != 0) ? 7'h0F : 7'($urandom_range(0, 127)),
                8'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic post(input int i);
        req_rnw[i] = c_rnw[i];
        req_write_mode[i] = c_wm[i];
        req_chip_addr[i*7 +: 7] = c_chip[i];
        req_reg_addr[i*8 +: 8] = c_reg[i];
        req_data[i*DW +: DW] = c_data[i];
        req_valid[i] = 1'b1;
        pend[i] = 1'b1;
    endtask

    task automatic model_reset();
        rr = 0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; reissue[i] = 0; end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, {33'd0, req_ack, rsp_valid, rsp_status, m_write_mode, m_write_en,
                            m_read_en, arb_busy, m_chip_addr, m_reg_addr}, 64'd0);
        chk({tag, "_dat"}, {rsp_data, m_data_in}, 64'd0);
    endtask

    // Serve one transaction: predict grant, check strobe, response and timing.
    task automatic serve_one(output int a, output int ack_lat, output int rsp_lat);
        int g, extra;
        bit got;
        logic [1:0]  bh;
        logic [3:0]  st;
        logic [31:0] dat;
        g = pick(); a = -1; ack_lat = 0; rsp_lat = 0; got = 0;
        while (!got && ack_lat < 50) begin
            @(negedge clk); ack_lat++; got = (req_ack != '0);
        end
        if (!got) begin
            chk("ack_timeout", 64'd0, 64'd1);
            model_reset();
            return;
        end
        chk("ack_grant", 64'(req_ack), 64'd1 << g);
        chk("arb_busy", 64'(arb_busy), 64'd1);
        for (int j = 0; j < N; j++) if (req_ack[j]) a = j;
        req_valid[a] = 1'b0; pend[a] = 0;
        @(negedge clk);
        chk("strobe", 64'({m_write_en, m_read_en}), c_rnw[a] ? 64'd1 : 64'd2);
        bh = {1'b0, m_busy}; extra = 0; got = 0;
        while (!got && rsp_lat < 400) begin
            @(negedge clk); rsp_lat++;
            if (rsp_valid != '0) got = 1;
            else begin
                if (m_write_en || m_read_en) extra++;
                bh = {bh[0], m_busy};
            end
        end
        chk("extra_strobe", 64'(extra), 64'd0);
        if (!got) begin chk("rsp_timeout", 64'd0, 64'd1); return; end
        if (mm_dead) begin
            st = 4'hE; dat = '0;
        end else if (c_chip[a] == 7'h0F) begin
            st = 4'h8;
            dat = c_rnw[a] ? ref_mem[c_reg[a]] : 32'h0;
            if (!c_rnw[a]) ref_mem[c_reg[a]] = c_data[a];
        end else begin
            st = 4'h1; dat = '0;
        end
        chk("rsp_onehot", 64'(rsp_valid), 64'd1 << a);
        chk("rsp_status", 64'(rsp_status), 64'(st));
        chk("rsp_data", 64'(rsp_data), 64'(dat));
        chk("m_fields", {m_write_mode, m_chip_addr, m_reg_addr, m_data_in},
            {c_wm[a], c_chip[a], c_reg[a], c_data[a]});
        if (!mm_dead) chk("busy_to_rsp", 64'(bh), 64'd2);
        rr = (a + 1) % N;
        if (reissue[a] > 0) begin reissue[a]--; rand_cmd(a); post(a); end
    endtask

    int a, al, rl, cnt, guard;
    logic [19:0] order;
    bit any_pend;

    initial begin
        req_valid = '0; req_rnw = '0; req_write_mode = '0;
        req_chip_addr = '0; req_reg_addr = '0; req_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        reset = 1'b1;
        @(negedge clk);

        // single write then read-back
        set_cmd(0, 1'b0, 7'h0F, 8'h0A, 32'h0000B2B2); post(0);
        serve_one(a, al, rl);
        chk("ack_lat", 64'(al), 64'd1);
        set_cmd(1, 1'b1, 7'h0F, 8'h0A, 32'h0); post(1);
        serve_one(a, al, rl);
        chk("readback", 64'(rsp_data), 64'h0000B2B2);

        // rsp_data/status hold after the pulse
        @(negedge clk);
        chk("rsp_hold", {28'd0, rsp_valid, rsp_status, rsp_data}, {32'd8, 32'h0000B2B2});

        // contention after reset, requester 0 re-asserts immediately
        @(negedge clk); reset = 1'b0; model_reset();
        repeat (2) @(negedge clk); reset = 1'b1; @(negedge clk);
        for (int i = 0; i < N; i++) begin rand_cmd(i); post(i); end
        reissue[0] = 1;
        order = '0;
        for (int k = 0; k < 5; k++) begin
            serve_one(a, al, rl);
            order = {order[15:0], 4'(a)};
        end
        chk("rr_order", 64'(order), 64'h01230);

        // master never starts
        mm_dead = 1;
        set_cmd(2, 1'b0, 7'h0F, 8'h01, 32'h1234); post(2);
        serve_one(a, al, rl);
        chk("nostart_st", 64'(rsp_status), 64'hE);
        chk("nostart_lat", 64'(rl), 64'(SW));
        mm_dead = 0;

        // busy master blocks grants; a request dropped before ack is forgotten
        force_busy = 1;
        set_cmd(2, 1'b1, 7'h0F, 8'h0A, 32'h0); post(2);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (req_ack != '0) cnt++; end
        chk("busy_blocks", 64'(cnt), 64'd0);
        req_valid[2] = 1'b0; pend[2] = 0; force_busy = 0;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (req_ack != '0) cnt++; end
        chk("dropped_req", 64'(cnt), 64'd0);
        post(2);
        serve_one(a, al, rl);

        // reset while the master is busy
        mm_len_fix = 40;
        set_cmd(3, 1'b1, 7'h0F, 8'h03, 32'h0); post(3);
        cnt = 0;
        while (req_ack == '0 && cnt < 20) begin @(negedge clk); cnt++; end
        req_valid[3] = 1'b0; pend[3] = 0;
        cnt = 0;
        while (!m_busy && cnt < 20) begin @(negedge clk); cnt++; end
        repeat (3) @(negedge clk);
        chk("busy_pre_rst", 64'(arb_busy), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        model_reset();
        mm_len_fix = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid != '0) cnt++; end
        chk("no_rsp_after_rst", 64'(cnt), 64'd0);
        for (int i = N - 1; i >= 0; i--) begin rand_cmd(i); post(i); end
        serve_one(a, al, rl);
        chk("post_rst_first", 64'(a), 64'd0);
        for (int k = 1; k < N; k++) serve_one(a, al, rl);

`ifdef I2C_ARB_TIMEOUT_EN
        mm_stuck = 1;
        set_cmd(1, 1'b0, 7'h33, 8'h05, 32'hCAFE); post(1);
        cnt = 0;
        while (req_ack == '0 && cnt < 20) begin @(negedge clk); cnt++; end
        req_valid[1] = 1'b0; pend[1] = 0;
        cnt = 0;
        while (!m_busy && cnt < 20) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (rsp_valid == '0 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("to_status", {rsp_status, rsp_data}, {4'hF, 32'h0});
        chk("to_lat", 64'(cnt), 64'(TO + 1));
        rr = 2;
        set_cmd(2, 1'b1, 7'h0F, 8'h0A, 32'h0); post(2);
        cnt = 0;
        repeat (10) begin @(negedge clk); if (req_ack != '0) cnt++; end
        chk("to_block", 64'(cnt), 64'd0);
        mm_stuck = 0;
        serve_one(a, al, rl);
`endif

        // randomized rounds
        for (int r = 0; r < 14; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) if (mask[i]) begin
                rand_cmd(i); reissue[i] = int'($urandom_range(0, 2)); post(i);
            end
            guard = 0;
            any_pend = 1;
            while (any_pend && guard < 40) begin
                serve_one(a, al, rl);
                guard++;
                any_pend = 0;
                for (int i = 0; i < N; i++) if (pend[i]) any_pend = 1;
            end
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Round-robin command scheduler that shares one i2c master instance (ADDR_BYTES=1, DATA_BYTES=4) between NUM_REQ independent requesters. Accepts one register read/write command per requester, sequences the master's write_en/read_en strobes, tracks busy to completion, and returns read data and status to the granted requester. Sits directly in front of the master's chip_addr/reg_addr/data_in/write_en/read_en/write_mode interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, data width; matches master DATA_BYTES*8
START_WAIT, 8, cycles allowed between strobe and master busy rising
TIMEOUT_CYCLES, 200000, busy watchdog limit (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command pending; held until req_ack
req_rnw  in  NUM_REQ  1=read, 0=write
req_write_mode  in  NUM_REQ  forwarded to master write_mode
req_chip_addr  in  NUM_REQ*7  7-bit chip address, requester i at [7i+6:7i]
req_reg_addr  in  NUM_REQ*8  register address, requester i at [8i+7:8i]
req_data  in  NUM_REQ*DATA_W  write data
req_ack  out  NUM_REQ  one-cycle one-hot pulse: command accepted
rsp_valid  out  NUM_REQ  one-cycle one-hot pulse: command finished
rsp_data  out  DATA_W  read data (0 for writes); valid with rsp_valid
rsp_status  out  4  master status or arbiter error code; valid with rsp_valid
m_chip_addr  out  7  to master chip_addr
m_reg_addr  out  8  to master reg_addr
m_data_in  out  DATA_W  to master data_in
m_write_mode  out  1  to master write_mode
m_write_en  out  1  to master write_en
m_read_en  out  1  to master read_en
m_data_out  in  DATA_W  from master data_out
m_status  in  4  from master status
m_busy  in  1  from master busy
arb_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=0, all outputs 0 (req_ack, rsp_valid, rsp_data, rsp_status, m_* regs, arb_busy). Reset mid-transaction abandons it; no rsp_valid issued.
- States: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> RESP -> IDLE.
- IDLE: if any req_valid and m_busy=0, grant highest-priority requester: search starts at (last_grant+1) mod NUM_REQ. Same cycle: register command fields into m_* outputs, pulse req_ack[g]; next state ISSUE. If m_busy=1 in IDLE, wait.
- ISSUE: m_write_en=~rnw or m_read_en=rnw for exactly one cycle; start counter=0; -> WAIT_START.
- WAIT_START: m_busy=1 -> WAIT_DONE. Counter reaches START_WAIT with m_busy still 0 -> RESP with status 4'hE (no start).
- WAIT_DONE: on m_busy falling to 0, capture m_status; capture m_data_out if rnw else 0; -> RESP.
- RESP: pulse rsp_valid[g] one cycle with rsp_data/rsp_status; update last_grant=g; -> IDLE. rsp_data/rsp_status hold until next RESP.
- m_* address/data outputs stay stable from grant until RESP exit.
- Latency: req_valid (idle arbiter) -> req_ack 1 cycle; req_ack -> strobe 1 cycle; rsp_valid 1 cycle after busy falls.
- req_valid dropped before ack: request simply not granted. Requester may re-assert req_valid in the cycle after its rsp_valid; it waits behind other pending requesters (fairness: a requester cannot win two grants in a row while another is pending).
- Simultaneous requests: strict rotation from last_grant+1; after reset lowest index first.

Optional Feature:
I2C_ARB_TIMEOUT_EN: defined -> 32-bit watchdog in WAIT_DONE; at TIMEOUT_CYCLES with m_busy still 1, go to RESP with rsp_status=4'hF, rsp_data=0, and hold in IDLE-grant-block until m_busy falls. Undefined -> WAIT_DONE waits indefinitely; counter logic absent.

Decomposition:
- Package i2c_arb_pkg: state encoding constants, status codes ST_NO_START=4'hE, ST_TIMEOUT=4'hF, field widths CHIP_W=7, REG_W=8.
- Sub-module i2c_rr_arbiter: combinational round-robin grant (req vector, last_grant -> one-hot grant + index), instantiated once.

Test Plan:
- Single write: req0 chip 0x0F reg 0x0A data 0xB2B2, slave attached -> req_ack[0] 1 cycle later, one m_write_en pulse, slave stores 0x0000B2B2 at 0x0A, rsp_valid[0] with status from master, rsp_data=0.
- Read-back: req1 read chip 0x0F reg 0x0A after above -> rsp_valid[1], rsp_data=0x0000B2B2.
- Contention: req0..req3 all valid same cycle after reset -> grants in order 0,1,2,3; with req0 re-asserted immediately, order 0,1,2,3,0, never 0 twice in a row.
- No start: master held disabled (busy stuck 0) -> rsp_status=4'hE exactly START_WAIT cycles after strobe.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, busy forced 1) -> rsp_status=4'hF after 50 cycles; no new grant until busy released.
- Reset mid-WAIT_DONE -> all outputs 0 immediately, no rsp_valid; next request after reset served from requester 0 priority.
